// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with iterative shifts and optional multiply
//
// Optional feature macro: ALU_MUL_EN (op 1000 = iterative unsigned multiply;
// when undefined op 1000 decodes as illegal and no multiplier is built).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready request handshake; op, a, b captured on accept
//   op[3:0]           operation select
//   a, b [WIDTH-1:0]  operands (b[SHW-1:0] is the shift amount)
//   out_valid/out_ready result handshake; outputs held while out_valid=1
//   result            registered result
//   carry             carry / borrow / last bit shifted out / mul high part nonzero
//   zero, neg         derived from the final result
//   ovf               signed overflow (ADD/SUB)
//   err               illegal op code
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
`endif

  // Iteration counter must reach WIDTH for the multiply, hence one extra bit.
  localparam int CW = SHW + 1;

  logic [1:0]       state;
  logic             up_q;     // low during reset and until the first clock after release
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work_q;   // shift operand, or multiplier/low product for MUL
  logic [CW-1:0]    cnt_q;    // remaining iterations
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;     // high half of the running product
`endif

  assign in_ready  = up_q && (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  logic accept;
  assign accept = in_valid && in_ready;

  // Single-cycle decode straight from the input operands.
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   dif_w;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] s_res;
  logic             s_c;
  logic             s_v;
  logic             s_e;
  logic             s_iter;

  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b};
    dif_w  = {1'b0, a} - {1'b0, b};
    amt    = b[SHW-1:0];
    s_res  = '0;
    s_c    = 1'b0;
    s_v    = 1'b0;
    s_e    = 1'b0;
    s_iter = 1'b0;
    case (op)
      OP_ADD: begin
        s_res = sum_w[WIDTH-1:0];
        s_c   = sum_w[WIDTH];
        s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = dif_w[WIDTH-1:0];
        s_c   = dif_w[WIDTH];   // borrow out of the unsigned subtraction
        s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: s_res = a & b;
      OP_OR:  s_res = a | b;
      OP_XOR: s_res = a ^ b;
      OP_NOT: s_res = ~a;
      OP_SHL, OP_SHR: begin
        // A zero-length shift completes immediately with nothing shifted out.
        if (amt == '0) s_res = a;
        else           s_iter = 1'b1;
      end
`ifdef ALU_MUL_EN
      OP_MUL: s_iter = 1'b1;
`endif
      default: s_e = 1'b1;
    endcase
  end

  // One iteration of the multi-cycle op held in op_q.
  logic [WIDTH-1:0] x_work;
  logic             x_c;
  logic             x_last;
`ifdef ALU_MUL_EN
  logic [WIDTH:0]   x_sum;
  logic [WIDTH-1:0] x_hi;
`endif

  always_comb begin
    x_last = (cnt_q == CW'(1));
    x_c    = work_q[0];
    x_work = {1'b0, work_q[WIDTH-1:1]};
    if (op_q == OP_SHL) begin
      x_c    = work_q[WIDTH-1];
      x_work = {work_q[WIDTH-2:0], 1'b0};
    end
`ifdef ALU_MUL_EN
    // Shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole {hi, lo} product right by one.
    x_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
    x_hi  = x_sum[WIDTH:1];
    if (op_q == OP_MUL) begin
      x_work = {x_sum[0], work_q[WIDTH-1:1]};
      x_c    = |x_hi;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      up_q    <= 1'b0;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q <= '0;
      hi_q    <= '0;
`endif
    end else begin
      up_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q <= op;
            if (s_iter) begin
              work_q <= a;
              cnt_q  <= {1'b0, amt};
`ifdef ALU_MUL_EN
              if (op == OP_MUL) begin
                work_q <= b;
                cnt_q  <= CW'(WIDTH);
              end
              mcand_q <= a;
              hi_q    <= '0;
`endif
              state <= S_EXEC;
            end else begin
              result <= s_res;
              carry  <= s_c;
              ovf    <= s_v;
              err    <= s_e;
              zero   <= (s_res == '0);
              neg    <= s_res[WIDTH-1];
              state  <= S_DONE;
            end
          end
        end
        S_EXEC: begin
          work_q <= x_work;
          cnt_q  <= cnt_q - CW'(1);
`ifdef ALU_MUL_EN
          hi_q   <= x_hi;
`endif
          if (x_last) begin
            result <= x_work;
            carry  <= x_c;
            ovf    <= 1'b0;
            err    <= 1'b0;
            zero   <= (x_work == '0);
            neg    <= x_work[WIDTH-1];
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=8)
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         carry, zero, neg, ovf, err;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         e;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic vec_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    vec_t   t;
    longint ux, uy, sx, sy, s, m, smax, smin;
    int     n;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    m = longint'(1) << W;
    smax = m / 2 - 1;
    smin = -(m / 2);
    n = int'(y) % W;
    t.op = o; t.a = x; t.b = y;
    t.r = '0; t.c = 1'b0; t.v = 1'b0; t.e = 1'b0; t.lat = 1;
    case (o)
      4'd0: begin
        s = ux + uy; t.r = W'(s); t.c = (s >= m);
        t.v = ((sx + sy) > smax) || ((sx + sy) < smin);
      end
      4'd1: begin
        s = ux - uy; t.r = W'(s); t.c = (ux < uy);
        t.v = ((sx - sy) > smax) || ((sx - sy) < smin);
      end
      4'd2: t.r = x & y;
      4'd3: t.r = x | y;
      4'd4: t.r = x ^ y;
      4'd5: t.r = ~x;
      4'd6: begin
        t.r = W'(ux << n);
        t.c = (n != 0) ? ((ux >> (W - n)) & 1) != 0 : 1'b0;
        t.lat = n + 1;
      end
      4'd7: begin
        t.r = W'(ux >> n);
        t.c = (n != 0) ? ((ux >> (n - 1)) & 1) != 0 : 1'b0;
        t.lat = n + 1;
      end
`ifdef ALU_MUL_EN
      4'd8: begin
        s = ux * uy; t.r = W'(s); t.c = (s >> W) != 0; t.lat = W + 1;
      end
`endif
      default: t.e = 1'b1;
    endcase
    return t;
  endfunction

  task automatic do_op(input vec_t t, input string name, input int hold);
    int k;
    int lat;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({name, ".in_ready"}, 64'(in_ready), 64'd1);
    op = t.op; a = t.a; b = t.b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({name, ".latency"}, 64'(lat), 64'(t.lat));
    check({name, ".result"}, 64'(result), 64'(t.r));
    check({name, ".carry"}, 64'(carry), 64'(t.c));
    check({name, ".ovf"}, 64'(ovf), 64'(t.v));
    check({name, ".err"}, 64'(err), 64'(t.e));
    check({name, ".zero"}, 64'(zero), 64'(t.r == '0));
    check({name, ".neg"}, 64'(neg), 64'(t.r[W-1]));
    repeat (hold) begin
      @(negedge clk);
      check({name, ".held"}, 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, t.r}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, ".idle"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t t;

    vecs.push_back('{4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'h1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h7, 8'hB4, 8'h03, 8'h16, 1'b1, 1'b0, 1'b0, 4});
    vecs.push_back('{4'h6, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h6, 8'h81, 8'h07, 8'h80, 1'b0, 1'b0, 1'b0, 8});
    vecs.push_back('{4'h7, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 2});
    vecs.push_back('{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'h5, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'hF, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1});
`ifdef ALU_MUL_EN
    vecs.push_back('{4'h8, 8'h13, 8'h0D, 8'hF7, 1'b0, 1'b0, 1'b0, 9});
    vecs.push_back('{4'h8, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 9});
`else
    vecs.push_back('{4'h8, 8'h13, 8'h0D, 8'h00, 1'b0, 1'b0, 1'b1, 1});
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset.outputs", 64'({in_ready, out_valid, result, carry, zero, neg, ovf, err}), 64'd0);
    rst = 1'b0;
    #1;
    check("reset.ready_low_at_release", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("reset.ready_after_release", 64'(in_ready), 64'd1);

    for (int i = 0; i < vecs.size(); i++)
      do_op(vecs[i], $sformatf("vec%0d", i), 0);

    // Backpressure: a second request must wait while the result is unconsumed.
    @(negedge clk);
    op = 4'h4; a = 8'hF0; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    op = 4'h0; a = 8'h01; b = 8'h01;
    @(negedge clk);
    check("bp.first", 64'({out_valid, result}), 64'({1'b1, 8'h0F}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp.hold%0d", i), 64'({out_valid, in_ready, result}), 64'({1'b1, 1'b0, 8'h0F}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp.release", 64'({out_valid, in_ready, result}), 64'({1'b0, 1'b1, 8'h0F}));

    // Reset in the middle of a 7-bit right shift.
    do_op(model(4'h1, 8'h03, 8'h05), "pre_rst", 0);
    op = 4'h7; a = 8'hA5; b = 8'h07; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.exec", 64'({out_valid, in_ready}), 64'd0);
    rst = 1'b1;
    #1;
    check("midrst.outputs", 64'({in_ready, out_valid, result, carry, zero, neg, ovf, err}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.after", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));
    repeat (8) @(negedge clk);
    check("midrst.no_stale", 64'({in_ready, out_valid}), 64'({1'b1, 1'b0}));

    // Randomised ops against the model, with random consumer backpressure.
    for (int i = 0; i < 40; i++) begin
      t = model(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
      do_op(t, $sformatf("rnd%0d", i), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the team's 4-bit combinational ALU.
- Accepts one operation at a time over a valid/ready input channel.
- Executes single-cycle ops in one clock; executes variable shifts (and, optionally, multiply) iteratively.
- Holds the registered result and a full flag set on a valid/ready output channel until it is consumed.
- Sits between an issuing controller/sequencer and a register-file writeback stage.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, 4..32.
SHW, $clog2(WIDTH), shift-amount field width (derived; do not override).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operation request valid.
in_ready  output  1  block can accept a request.
op  input  4  operation select (encoding below).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B; for shifts, b[SHW-1:0] is the amount.
out_valid  output  1  result/flags valid.
out_ready  input  1  consumer accepts result.
result  output  WIDTH  registered result.
carry  output  1  carry / borrow / last bit shifted out / multiply high-part-nonzero.
zero  output  1  result == 0.
neg  output  1  result[WIDTH-1].
ovf  output  1  signed overflow (ADD/SUB only).
err  output  1  illegal op code.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Port names are clk and rst.
- Reset (async assert, any state, including mid-operation):
  - State returns to IDLE; any in-flight op is discarded.
  - out_valid, result, carry, zero, neg, ovf, err all go to 0.
  - in_ready is 0 while rst is high and 1 from the first clock after rst deasserts.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - EXEC: iterating; in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0; outputs held stable.
- Transitions:
  - IDLE -> DONE on accept (in_valid & in_ready) of a single-cycle op, or of a shift with amount 0. Latency is 1 cycle.
  - IDLE -> EXEC on accept of a shift with amount N>0, or of MUL.
  - EXEC -> DONE after the last iteration. Shift latency is N+1 cycles; MUL latency is WIDTH+1 cycles.
  - DONE -> IDLE on out_valid & out_ready.
  - Without out_ready, DONE holds indefinitely (backpressure) and no new request is accepted.
  - Back-to-back: the earliest next accept is the cycle after the output handshake.
- Operands and op are captured at accept; input changes afterwards have no effect.
- Op encoding, with all arithmetic modulo 2^WIDTH:
  - 0000 ADD: carry = bit WIDTH of a+b; ovf = signs of a and b equal and result sign differs.
  - 0001 SUB a-b: carry = borrow (a<b unsigned); ovf = signs of a and b differ and result sign differs from a.
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOT a: carry=0, ovf=0.
  - 0110 SHL a by b[SHW-1:0]: logical, one bit per EXEC cycle; carry = last bit shifted out (0 if N=0); ovf=0.
  - 0111 SHR a by b[SHW-1:0]: logical right shift, otherwise as SHL.
  - 1000 MUL: see Optional Feature.
  - 1001..1111: illegal; latency 1, result=0, carry=0, ovf=0, err=1, zero=1.
- zero and neg are always derived from the final result. err=0 for every legal op.
- Every flag is assigned for every op; no flag retains a stale value from a previous op.

Optional Feature:
Macro ALU_MUL_EN.
- Defined:
  - op 1000 = unsigned MUL, computed by iterative shift-add, one multiplier bit per EXEC cycle (WIDTH cycles).
  - result = low WIDTH bits of a*b; carry = 1 if the high WIDTH bits are nonzero; ovf=0.
- Undefined:
  - No multiplier logic is synthesised.
  - op 1000 is treated as illegal (err=1, latency 1, as above).

Test Plan (WIDTH=8):
- Reset mid-shift: accept SHR amount 7, assert rst in the 3rd EXEC cycle -> all outputs 0 immediately; in_ready=1 the cycle after release; no stale out_valid.
- ADD a=0x7F b=0x01 -> 1 cycle later out_valid=1, result=0x80, carry=0, ovf=1, neg=1, zero=0. SUB 0x03-0x05 -> 0xFE, carry=1, ovf=0, neg=1.
- SHR a=0xB4 b=0x03 -> out_valid 4 cycles after accept, result=0x16, carry=1. SHL a=0x81 b=0x00 -> latency 1, result=0x81, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR 0xF0^0xFF -> result=0x0F held stable, in_ready=0 throughout, a new in_valid is not accepted; release out_ready -> IDLE the next cycle.
- ALU_MUL_EN defined:
  - 0x13*0x0D -> 0xF7, carry=0, latency 9.
  - 0x20*0x10 -> 0x00, carry=1, zero=1.
- ALU_MUL_EN undefined:
  - op=1000 -> err=1, result=0, latency 1.
- op=1111 -> err=1, result=0, zero=1, in both builds.
